// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA capture block.
package vga_pkg;

  localparam int DEFAULT_H_ACTIVE = 640;
  localparam int DEFAULT_V_ACTIVE = 480;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] rgb;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } cap_state_t;

  // Bit-serial CRC-16-CCITT update over one byte, MSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage array; contents are only meaningful behind the count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vga_capture.sv
// VGA receive-side capture: registers the raw VGA signals, rebuilds pixel
// coordinates and streams {x, y, rgb} through a small FWFT FIFO.
// Optional frame CRC output is enabled by defining VGA_CAPTURE_CRC_EN.
module vga_capture
  import vga_pkg::*;
#(
  parameter int H_ACTIVE        = DEFAULT_H_ACTIVE,
  parameter int V_ACTIVE        = DEFAULT_V_ACTIVE,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [2:0]  red,
  input  logic [2:0]  green,
  input  logic [1:0]  blue,
  input  logic        video_enable,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [7:0]  pix_rgb,
  output logic        frame_start,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        timing_err,
  output logic        overflow,
  input  logic        err_clr
`ifdef VGA_CAPTURE_CRC_EN
  ,
  output logic [15:0] frame_crc
`endif
);

  localparam logic       SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);
  localparam logic [9:0] H_MAX     = 10'(H_ACTIVE);
  localparam logic [8:0] V_LAST    = 9'(V_ACTIVE - 1);

  logic       hs_s1, vs_s1, de_s1, vs_prev, de_prev;
  logic [7:0] rgb_s1;
  logic       hs_act, vs_act, vs_prev_act, vs_edge, de_fall;

  cap_state_t state, state_n;
  logic [9:0] x, x_n;
  logic [8:0] y, y_n;
  logic       push, err_set, start_n, done_n, overflow_set;
  pixel_t     push_pix, head_pix;
  logic       fifo_full, fifo_empty, fifo_pop;

  // Input stage: one register on every VGA input plus a history copy for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_s1   <= SYNC_IDLE;
      vs_s1   <= SYNC_IDLE;
      de_s1   <= 1'b0;
      rgb_s1  <= 8'h00;
      vs_prev <= SYNC_IDLE;
      de_prev <= 1'b0;
    end else begin
      hs_s1   <= h_sync;
      vs_s1   <= v_sync;
      de_s1   <= video_enable;
      rgb_s1  <= {red, green, blue};
      vs_prev <= vs_s1;
      de_prev <= de_s1;
    end
  end

  assign hs_act      = hs_s1 ^ SYNC_IDLE;
  assign vs_act      = vs_s1 ^ SYNC_IDLE;
  assign vs_prev_act = vs_prev ^ SYNC_IDLE;
  assign vs_edge     = vs_act & ~vs_prev_act;
  assign de_fall     = de_prev & ~de_s1;

  // Capture FSM: decides pushes, coordinate updates, frame pulses and timing errors.
  always_comb begin
    state_n  = state;
    x_n      = x;
    y_n      = y;
    push     = 1'b0;
    err_set  = 1'b0;
    start_n  = 1'b0;
    done_n   = 1'b0;
    if (hs_act && de_s1) err_set = 1'b1;
    if (vs_edge) begin
      start_n = 1'b1;
      state_n = ARMED;
      x_n     = '0;
      y_n     = '0;
      if (state == ACTIVE) err_set = 1'b1;
    end else begin
      case (state)
        ARMED: begin
          if (de_s1) begin
            push    = 1'b1;
            x_n     = x + 10'd1;
            state_n = ACTIVE;
          end
        end
        ACTIVE: begin
          if (de_s1) begin
            if (x < H_MAX) begin
              push = 1'b1;
              x_n  = x + 10'd1;
            end else begin
              err_set = 1'b1;
            end
          end else if (de_fall) begin
            if (x != H_MAX) err_set = 1'b1;
            x_n = '0;
            if (y == V_LAST) begin
              done_n  = 1'b1;
              y_n     = '0;
              state_n = DONE;
            end else begin
              y_n = y + 9'd1;
            end
          end
        end
        DONE: begin
          if (de_s1) err_set = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign push_pix.x   = x;
  assign push_pix.y   = y;
  assign push_pix.rgb = rgb_s1;

  assign pix_valid    = ~fifo_empty;
  assign fifo_pop     = pix_valid & pix_ready;
  assign overflow_set = push & fifo_full & ~fifo_pop;

  // State, counters and sticky flags; a fresh error outranks err_clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 16'h0000;
      timing_err  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_n;
      x           <= x_n;
      y           <= y_n;
      frame_start <= start_n;
      frame_done  <= done_n;
      frame_count <= frame_count + 16'(done_n);
      timing_err  <= err_set | (timing_err & ~err_clr);
      overflow    <= overflow_set | (overflow & ~err_clr);
    end
  end

  sync_fifo #(
    .WIDTH ($bits(pixel_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_pix),
    .pop       (fifo_pop),
    .pop_data  (head_pix),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pix_x   = pix_valid ? head_pix.x   : 10'd0;
  assign pix_y   = pix_valid ? head_pix.y   : 9'd0;
  assign pix_rgb = pix_valid ? head_pix.rgb : 8'h00;

`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] crc_run;

  // Running CRC over the rgb bytes of each frame, latched alongside frame_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_run   <= CRC_INIT;
      frame_crc <= 16'h0000;
    end else begin
      if (start_n)   crc_run <= CRC_INIT;
      else if (push) crc_run <= crc16_byte(crc_run, rgb_s1);
      if (done_n)    frame_crc <= crc_run;
    end
  end
`endif

endmodule
